// File: rtl/fp16_pkg.sv
// Shared binary16 constants, operand classification and the unpacked-operand
// type used by the fp16 arithmetic blocks.
package fp16_pkg;

   localparam int EXP_W    = 5;
   localparam int MAN_W    = 10;
   localparam int EXP_BIAS = 15;

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;

   typedef enum logic [1:0] {
      ZERO,
      NORM,
      INF,
      NAN
   } fp_class_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expo;
      logic [MAN_W-1:0] man;
      fp_class_e        cls;
   } fp16_unpacked_t;

   // Subnormal inputs are classified as ZERO, which flushes them on entry.
   function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x);
      fp16_unpacked_t u;
      u.sign = x[15];
      u.expo = x[14:10];
      u.man  = x[9:0];
      if (x[14:10] == 5'd0) begin
         u.cls = ZERO;
      end else if (x[14:10] == 5'h1F) begin
         u.cls = (x[9:0] != 10'd0) ? NAN : INF;
      end else begin
         u.cls = NORM;
      end
      return u;
   endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Normalize, round-to-nearest-even and pack a raw 22-bit significand product
// into binary16, applying special-case and range overrides.
module fp16_round_pack
   import fp16_pkg::*;
(
   input  logic              sign,
   input  logic signed [6:0] exp_sum,
   input  logic [21:0]       prod,
   input  logic              is_nan,
   input  logic              is_inf,
   input  logic              is_zero,
   output logic [15:0]       result
);

   logic [10:0]       mant;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic [11:0]       mant_rnd;
   logic [9:0]        frac;
   logic signed [7:0] exp_n;
   logic signed [7:0] exp_adj;

   always_comb begin
      mant     = prod[20:10];
      guard    = prod[9];
      sticky   = |prod[8:0];
      exp_n    = {exp_sum[6], exp_sum};
      round_up = 1'b0;
      mant_rnd = 12'd0;
      frac     = 10'd0;
      exp_adj  = 8'sd0;
      result   = 16'h0000;

      // A product in [2,4) has its leading one at bit 21.
      if (prod[21]) begin
         mant   = prod[21:11];
         guard  = prod[10];
         sticky = |prod[9:0];
         exp_n  = {exp_sum[6], exp_sum} + 8'sd1;
      end

      round_up = guard & (sticky | mant[0]);
      mant_rnd = {1'b0, mant} + {11'd0, round_up};
      frac     = mant_rnd[11] ? mant_rnd[10:1] : mant_rnd[9:0];
      exp_adj  = exp_n + $signed({7'd0, mant_rnd[11]});

      if (is_nan) begin
         result = QNAN;
      end else if (is_inf) begin
         result = {sign, POS_INF[14:0]};
      end else if (is_zero) begin
         result = {sign, 15'd0};
      end else if (exp_adj >= 8'sd31) begin
         result = {sign, POS_INF[14:0]};
      end else if (exp_adj <= 8'sd0) begin
         result = {sign, 15'd0};
      end else begin
         result = {sign, exp_adj[4:0], frac};
      end
   end

endmodule

// File: rtl/fp16_axis_mult.sv
// Three-stage pipelined binary16 multiplier with AXI-Stream style operand and
// result channels; the whole pipeline stalls together under backpressure.
module fp16_axis_mult #(
   parameter int DATA_WIDTH = 16,
   parameter int EXP_W      = 5,
   parameter int MAN_W      = 10,
   parameter int EXP_BIAS   = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_a_tvalid,
   output logic                  s_axis_a_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_a_tdata,
   input  logic                  s_axis_b_tvalid,
   output logic                  s_axis_b_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_b_tdata,
   output logic                  m_axis_result_tvalid,
   input  logic                  m_axis_result_tready,
   output logic [DATA_WIDTH-1:0] m_axis_result_tdata
);
   import fp16_pkg::*;

   if (DATA_WIDTH != 16 || EXP_W != 5 || MAN_W != 10 || EXP_BIAS != 15) begin : g_param_check
      $error("fp16_axis_mult only supports IEEE-754 binary16 (16/5/10/15)");
   end

   logic              en;
   logic              accept;
   logic              v1;
   logic              v2;
   logic              v3;
   fp16_unpacked_t    s1_a;
   fp16_unpacked_t    s1_b;
   logic [21:0]       prod_c;
   logic signed [6:0] exp_c;
   logic              nan_c;
   logic              inf_c;
   logic              zero_c;
   logic              s2_sign;
   logic signed [6:0] s2_exp;
   logic [21:0]       s2_prod;
   logic              s2_nan;
   logic              s2_inf;
   logic              s2_zero;
   logic [15:0]       rp_result;
   logic [15:0]       s3_data;

   assign en              = !v3 || m_axis_result_tready;
   assign accept          = en && s_axis_a_tvalid && s_axis_b_tvalid;
   assign s_axis_a_tready = en && rst_n;
   assign s_axis_b_tready = en && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
      end else if (en) begin
         v1 <= accept;
         if (accept) begin
            s1_a <= fp16_unpack(s_axis_a_tdata);
            s1_b <= fp16_unpack(s_axis_b_tdata);
         end
      end
   end

   // inf x zero is invalid and must outrank the plain infinity case.
   always_comb begin
      prod_c = 22'({1'b1, s1_a.man}) * 22'({1'b1, s1_b.man});
      exp_c  = 7'(s1_a.expo) + 7'(s1_b.expo) - 7'(EXP_BIAS);
      nan_c  = (s1_a.cls == NAN) || (s1_b.cls == NAN) ||
               (s1_a.cls == INF && s1_b.cls == ZERO) ||
               (s1_b.cls == INF && s1_a.cls == ZERO);
      inf_c  = (s1_a.cls == INF) || (s1_b.cls == INF);
      zero_c = (s1_a.cls == ZERO) || (s1_b.cls == ZERO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_exp  <= '0;
         s2_prod <= '0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
      end else if (en) begin
         v2 <= v1;
         if (v1) begin
            s2_sign <= s1_a.sign ^ s1_b.sign;
            s2_exp  <= exp_c;
            s2_prod <= prod_c;
            s2_nan  <= nan_c;
            s2_inf  <= inf_c;
            s2_zero <= zero_c;
         end
      end
   end

   fp16_round_pack u_round_pack (
      .sign    (s2_sign),
      .exp_sum (s2_exp),
      .prod    (s2_prod),
      .is_nan  (s2_nan),
      .is_inf  (s2_inf),
      .is_zero (s2_zero),
      .result  (rp_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3      <= 1'b0;
         s3_data <= 16'h0000;
      end else if (en) begin
         v3 <= v2;
         if (v2) begin
            s3_data <= rp_result;
         end
      end
   end

   assign m_axis_result_tvalid = v3;
   assign m_axis_result_tdata  = s3_data;

endmodule

// File: tb/tb_fp16_axis_mult.sv
// Randomized and directed bench for fp16_axis_mult against an arithmetic
// reference model, with protocol, hold, latency and reset checks.
module tb_fp16_axis_mult;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [15:0] a_data = 16'h0000;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [15:0] b_data = 16'h0000;
   logic        r_valid;
   logic        r_ready = 1'b1;
   logic [15:0] r_data;

   typedef struct {
      logic [15:0] data;
      int          acc_cyc;
      bit          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          n_compared = 0;
   int          n_mismatched = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   int          bp_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0000;

   always #5 clk = ~clk;

   fp16_axis_mult dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .s_axis_a_tvalid      (a_valid),
      .s_axis_a_tready      (a_ready),
      .s_axis_a_tdata       (a_data),
      .s_axis_b_tvalid      (b_valid),
      .s_axis_b_tready      (b_ready),
      .s_axis_b_tdata       (b_data),
      .m_axis_result_tvalid (r_valid),
      .m_axis_result_tready (r_ready),
      .m_axis_result_tdata  (r_data)
   );

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Product value is M * 2^(ea+eb-50) with M the product of the 11-bit significands.
   function automatic logic [15:0] refMul(input logic [15:0] a, input logic [15:0] b);
      int     ea, eb, fa, fb, msb, shift, biased;
      longint m, q, rem, half;
      logic   s;
      bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      fa = int'(a[9:0]);
      fb = int'(b[9:0]);
      s  = a[15] ^ b[15];
      a_nan  = (ea == 31) && (fa != 0);
      b_nan  = (eb == 31) && (fb != 0);
      a_inf  = (ea == 31) && (fa == 0);
      b_inf  = (eb == 31) && (fb == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
      if (a_inf || b_inf) return {s, 15'h7C00};
      if (a_zero || b_zero) return {s, 15'h0000};
      m = longint'(1024 + fa) * longint'(1024 + fb);
      msb = 0;
      while ((m >> (msb + 1)) != 0) msb++;
      shift = msb - 10;
      q     = m >> shift;
      rem   = m - (q << shift);
      half  = longint'(1) << (shift - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      biased = ea + eb - 35 + msb;
      if (q == 2048) begin
         q = 1024;
         biased++;
      end
      if (biased >= 31) return {s, 15'h7C00};
      if (biased <= 0) return {s, 15'h0000};
      return {s, 5'(biased), 10'(q - 1024)};
   endfunction

   function automatic logic [15:0] randOperand();
      int r;
      r = $urandom_range(0, 5);
      if (r == 0) return 16'($urandom);
      if (r == 1) begin
         case ($urandom_range(0, 6))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7E01;
            5: return 16'h0001;
            default: return 16'h3C00;
         endcase
      end
      return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: r_ready = 1'b1;
         1: begin
            r_ready = (bp_cnt % 3 == 0);
            bp_cnt++;
         end
         2: r_ready = ($urandom_range(0, 3) != 0);
         default: r_ready = 1'b0;
      endcase
   end

   // Output monitor: readiness rule, stall hold, ordered results and latency.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         checkOutput("ready_a", {15'd0, a_ready}, {15'd0, (!r_valid || r_ready)});
         checkOutput("ready_b", {15'd0, b_ready}, {15'd0, (!r_valid || r_ready)});
         if (prev_stall) begin
            checkOutput("hold_valid", {15'd0, r_valid}, 16'd1);
            checkOutput("hold_data", r_data, prev_data);
         end
         if (r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_result", {15'd0, r_valid}, 16'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("result", r_data, e.data);
               if (e.lat) checkOutput("latency", 16'(cyc - e.acc_cyc), 16'd3);
            end
         end
         prev_stall = r_valid && !r_ready;
         prev_data  = r_data;
      end
   end

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] expected, input bit lat, input int lone_a);
      bit done;
      exp_t e;
      done    = 1'b0;
      a_data  = a;
      b_data  = b;
      a_valid = 1'b1;
      b_valid = (lone_a == 0);
      repeat (lone_a) begin
         @(posedge clk);
         #1;
      end
      b_valid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (a_ready) begin
            e.data    = expected;
            e.acc_cyc = cyc;
            e.lat     = lat;
            exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("accept_timeout", {15'd0, a_ready}, 16'd1);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
      checkOutput("drain_left", 16'(exp_q.size()), 16'd0);
      @(posedge clk);
      #1;
   endtask

   logic [15:0] dir_a[11] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h3C01, 16'h7BFF, 16'h0400,
                              16'h8400, 16'h7C00, 16'h7E00, 16'hFC00, 16'h4000};
   logic [15:0] dir_b[11] = '{16'h4000, 16'h3E00, 16'h4200, 16'h3C01, 16'h4000, 16'h3800,
                              16'h3800, 16'h0000, 16'h3C00, 16'h4000, 16'h4000};
   logic [15:0] dir_r[11] = '{16'h4000, 16'h4080, 16'hC600, 16'h3C02, 16'h7C00, 16'h0000,
                              16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h4400};

   initial begin
      logic [15:0] ra, rb;
      bit seen;

      #12;
      checkOutput("reset_tvalid", {15'd0, r_valid}, 16'd0);
      checkOutput("reset_tdata", r_data, 16'h0000);
      checkOutput("reset_a_ready", {15'd0, a_ready}, 16'd0);
      checkOutput("reset_b_ready", {15'd0, b_ready}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed products");
      for (int i = 0; i < 11; i++) applyStimulus(dir_a[i], dir_b[i], dir_r[i], 1'b1, (i == 10) ? 3 : 0);
      waitDrain();

      $display("[TB] backpressure stream");
      bp_cnt = 0;
      ready_mode = 1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) applyStimulus(16'h4000 + 16'(k), 16'h3C00, 16'h4000 + 16'(k), 1'b0, 0);
      waitDrain();
      ready_mode = 0;

      $display("[TB] reset mid-operation");
      ready_mode = 3;
      @(posedge clk);
      #1;
      applyStimulus(16'h3C00, 16'h4000, 16'h4000, 1'b0, 0);
      applyStimulus(16'h4400, 16'h3C00, 16'h4400, 1'b0, 0);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = r_valid;
      end
      checkOutput("stalled_valid", {15'd0, r_valid}, 16'd1);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("async_rst_tvalid", {15'd0, r_valid}, 16'd0);
      checkOutput("async_rst_tdata", r_data, 16'h0000);
      checkOutput("async_rst_ready", {15'd0, a_ready}, 16'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 0;
      repeat (6) @(posedge clk);
      #1;
      applyStimulus(16'h4000, 16'h4000, 16'h4400, 1'b1, 0);
      waitDrain();

      $display("[TB] randomized stream");
      ready_mode = 2;
      for (int n = 0; n < 300; n++) begin
         ra = randOperand();
         rb = randOperand();
         applyStimulus(ra, rb, refMul(ra, rb), 1'b0, ($urandom_range(0, 9) == 0) ? 2 : 0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      ready_mode = 0;
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
